// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM front-end: default widths, access length,
// counter width and the controller state encoding.
package sram_ctrl_pkg;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ACC_CYCLES = 2;

    // Wide enough for ACC_CYCLES-1 with ACC_CYCLES up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response channel between a clocked master and the SRAM front-end.
//   req_valid/req_ready : request handshake (accept on valid & ready)
//   req_write/addr/wdata: request payload, sampled on acceptance
//   rsp_valid/rsp_rdata : one-cycle read response, data held until next read
//   busy                : controller is not idle
interface sram_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/sram_ctrl.sv
// Synchronous front-end for an asynchronous single-port SRAM macro.
// Each accepted request walks SETUP -> ACCESS (ACC_CYCLES) -> HOLD so that
// address, read/write select and write data are settled before chip select
// rises and stay put until after it falls.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : request/response channel (slave side)
//   sram_addr : SRAM address
//   sram_data : SRAM data bus, driven only while a write is in progress
//   sram_rws  : SRAM read/write select (1 = write)
//   sram_cs   : SRAM chip select
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_CYCLES = DEF_ACC_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_rws,
    output logic              sram_cs
);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rws;
    logic [DATA_W-1:0] r_wdata;
    logic              r_oe;
    logic              r_cs;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              w_accept;
    logic              w_capture;

    // Ready is combinational so a request held across reset release is
    // taken on the very first edge after rst drops.
    assign bus.req_ready = (r_state == IDLE) && !rst;
    assign bus.busy      = (r_state != IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;

    assign w_accept  = bus.req_valid && bus.req_ready;
    assign w_capture = (r_state == ACCESS) && (r_cnt == '0) && !r_rws;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = SETUP;
            end
            SETUP: begin
                w_state_next = ACCESS;
                w_cnt_next   = CNT_W'(ACC_CYCLES - 1);
            end
            ACCESS: begin
                if (r_cnt == '0) w_state_next = HOLD;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            HOLD: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // All pin controls are registered (decoded from the next state) so
    // chip select and the bus enable come straight off flops and cannot glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_rws       <= 1'b0;
            r_wdata     <= '0;
            r_oe        <= 1'b0;
            r_cs        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // Address/select only move on acceptance, when cs is low on
            // both sides of the edge.
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_rws   <= bus.req_write;
                r_wdata <= bus.req_wdata;
            end
            r_cs        <= (w_state_next == ACCESS);
            r_oe        <= (w_state_next != IDLE) && (w_accept ? bus.req_write : r_rws);
            r_rsp_valid <= w_capture;
            if (w_capture) r_rsp_rdata <= sram_data;
        end
    end

    assign sram_addr = r_addr;
    assign sram_rws  = r_rws;
    assign sram_cs   = r_cs;
    assign sram_data = r_oe ? r_wdata : {DATA_W{1'bz}};

    a_pins_stable: assert property (@(posedge clk) disable iff (rst)
        (!$stable(sram_addr) || !$stable(sram_rws)) |-> (!sram_cs && !$past(sram_cs)));

    a_no_contention: assert property (@(posedge clk) disable iff (rst)
        !(r_oe && sram_cs && !sram_rws));

    a_drive_only_writes: assert property (@(posedge clk) disable iff (rst)
        r_oe |-> (r_rws && (r_state != IDLE)));

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two controllers (ACC_CYCLES=2 and 1), each with a
// behavioural asynchronous SRAM as load, driven through one shared stimulus
// path selected by 'sel'. Expectations come from a memory-image model plus
// the phase timing (SETUP 1, ACCESS ACC, HOLD 1).
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          t_valid;
    logic          t_write;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic          sel;     // 0: ACC_CYCLES=2 instance, 1: ACC_CYCLES=1 instance

    sram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
    sram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    assign bus2.req_valid = t_valid & ~sel;
    assign bus2.req_write = t_write;
    assign bus2.req_addr  = t_addr;
    assign bus2.req_wdata = t_wdata;
    assign bus1.req_valid = t_valid & sel;
    assign bus1.req_write = t_write;
    assign bus1.req_addr  = t_addr;
    assign bus1.req_wdata = t_wdata;

    wire  [DW-1:0] data2;
    wire  [DW-1:0] data1;
    logic [AW-1:0] addr2, addr1;
    logic          rws2, rws1, cs2, cs1;

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .sram_addr(addr2), .sram_data(data2), .sram_rws(rws2), .sram_cs(cs2)
    );

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .sram_addr(addr1), .sram_data(data1), .sram_rws(rws1), .sram_cs(cs1)
    );

    // SRAM loads: read data appears while selected for read, writes land
    // while selected for write.
    logic [DW-1:0] mem2 [1<<AW];
    logic [DW-1:0] mem1 [1<<AW];
    assign data2 = (cs2 && !rws2) ? mem2[addr2] : {DW{1'bz}};
    assign data1 = (cs1 && !rws1) ? mem1[addr1] : {DW{1'bz}};
    always @(posedge clk) if (cs2 && rws2) mem2[addr2] <= data2;
    always @(posedge clk) if (cs1 && rws1) mem1[addr1] <= data1;

    wire          o_ready  = sel ? bus1.req_ready : bus2.req_ready;
    wire          o_busy   = sel ? bus1.busy      : bus2.busy;
    wire          o_rvalid = sel ? bus1.rsp_valid : bus2.rsp_valid;
    wire [DW-1:0] o_rdata  = sel ? bus1.rsp_rdata : bus2.rsp_rdata;
    wire          o_cs     = sel ? cs1   : cs2;
    wire          o_rws    = sel ? rws1  : rws2;
    wire [AW-1:0] o_addr   = sel ? addr1 : addr2;
    wire [DW-1:0] o_data   = sel ? data1 : data2;

    // Reference model: memory image per instance, last returned read data,
    // and the set of written addresses for random reads.
    logic [DW-1:0] ref_mem [2][1<<AW];
    logic [DW-1:0] last_rd [2];
    logic [AW-1:0] wq [$];
    logic          prev_hold = 1'b0;
    int            prev_acc  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One request, followed cycle by cycle until ready returns.
    task automatic run_txn(input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic hold);
        int acc;
        int guard;
        int t_acc;
        logic [DW-1:0] exp_rd;
        acc   = sel ? 1 : 2;
        guard = 0;
        while (!o_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", guard < 50, 1);
        t_valid = 1'b1;
        t_write = w;
        t_addr  = a;
        t_wdata = d;
        @(posedge clk);
        #1;
        t_acc = cyc;
        if (prev_hold) chk("b2b_gap", t_acc - prev_acc, acc + 3);
        prev_acc  = t_acc;
        prev_hold = hold;
        if (!hold) t_valid = 1'b0;
        for (int k = 1; k <= acc + 3; k++) begin
            @(negedge clk);
            chk("cs", o_cs, (k >= 2) && (k <= acc + 1));
            chk("busy", o_busy, k < acc + 3);
            chk("ready", o_ready, k == acc + 3);
            chk("rsp_valid", o_rvalid, !w && (k == acc + 2));
            exp_rd = (!w && k >= acc + 2) ? ref_mem[sel][a] : last_rd[sel];
            chk("rsp_rdata", o_rdata, exp_rd);
            chk("sram_addr", o_addr, a);
            chk("sram_rws", o_rws, w);
            if (w && k <= acc + 2) chk("sram_data", o_data, d);
        end
        if (w) begin
            ref_mem[sel][a] = d;
            wq.push_back(a);
        end else begin
            last_rd[sel] = ref_mem[sel][a];
        end
        $display("txn sel=%0d %s addr=0x%03h data=0x%02h hold=%0d at cycle %0d",
                 sel, w ? "WR" : "RD", a, w ? d : ref_mem[sel][a], hold, t_acc);
    endtask

    task automatic rand_txns(input int n);
        for (int i = 0; i < n; i++) begin
            logic          w;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic          h;
            w = (wq.size() == 0) || ($urandom_range(0, 1) == 1);
            if (w) begin
                case ($urandom_range(0, 3))
                    0:       a = '0;
                    1:       a = '1;
                    default: a = AW'($urandom_range(0, (1 << AW) - 1));
                endcase
            end else begin
                a = wq[$urandom_range(0, wq.size() - 1)];
            end
            d = DW'($urandom);
            h = (i != n - 1) && ($urandom_range(0, 1) == 1);
            run_txn(w, a, d, h);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        t_valid = 1'b0;
        t_write = 1'b0;
        t_addr  = '0;
        t_wdata = '0;
        sel     = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_ready", o_ready, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_cs", o_cs, 0);
            chk("rst_rvalid", o_rvalid, 0);
            chk("rst_rdata", o_rdata, 0);
            chk("rst_addr", o_addr, 0);
            chk("rst_rws", o_rws, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Single write then read-back.
        run_txn(1'b1, 10'h155, 8'hA5, 1'b0);
        run_txn(1'b0, 10'h155, 8'h00, 1'b0);

        // Back-to-back with valid held high, both address extremes.
        run_txn(1'b1, 10'h000, 8'h3C, 1'b1);
        run_txn(1'b1, 10'h3FF, 8'hC3, 1'b1);
        run_txn(1'b0, 10'h000, 8'h00, 1'b1);
        run_txn(1'b0, 10'h3FF, 8'h00, 1'b0);

        // Write/read alternation at one address.
        run_txn(1'b1, 10'h200, 8'h11, 1'b0);
        run_txn(1'b0, 10'h200, 8'h00, 1'b0);
        run_txn(1'b1, 10'h200, 8'h22, 1'b0);
        run_txn(1'b0, 10'h200, 8'h00, 1'b0);

        // Reset during the ACCESS phase of a read; a write is then held
        // valid across reset release.
        run_txn(1'b1, 10'h010, 8'h96, 1'b0);
        t_valid = 1'b1;
        t_write = 1'b0;
        t_addr  = 10'h010;
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_cs", o_cs, 1);
        rst     = 1'b1;
        t_valid = 1'b1;
        t_write = 1'b1;
        t_wdata = 8'h77;
        @(negedge clk);
        chk("midrst_cs", o_cs, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_ready", o_ready, 0);
        chk("midrst_rvalid", o_rvalid, 0);
        @(negedge clk);
        chk("midrst_ready2", o_ready, 0);
        chk("midrst_rvalid2", o_rvalid, 0);
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        #1;
        chk("rel_ready", o_ready, 1);
        run_txn(1'b1, 10'h010, 8'h77, 1'b0);
        run_txn(1'b0, 10'h010, 8'h00, 1'b0);

        rand_txns(40);

        // Single-cycle access instance.
        sel = 1'b1;
        wq.delete();
        #1;
        run_txn(1'b1, 10'h2AA, 8'h5A, 1'b0);
        run_txn(1'b0, 10'h2AA, 8'h00, 1'b0);
        rand_txns(20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
